// File: rtl/div_ctrl.sv
// div_ctrl: iterative divide controller for the execute stage.
// Sequences a radix-2 restoring divider (one quotient bit per cycle) for
// DIV.W / MOD.W / DIV.WU / MOD.WU. It requests a pipeline pause while a
// result is outstanding. It also caches the last quotient/remainder pair, so
// a DIV followed by a MOD on identical operands costs only one division.
//
// Ports:
//   clk, rst      clock (rising edge), synchronous active-high reset
//   start_i       divide-class op present; level, held until valid_o
//   signed_i      1 = signed (DIV.W/MOD.W), 0 = unsigned
//   mod_i         1 = return remainder, 0 = return quotient
//   dividend_i    rj operand
//   divisor_i     rk operand
//   cancel_i      pipeline flush; aborts the current operation
//   result_o      quotient or remainder; valid while valid_o=1, then held
//   valid_o       single-cycle result pulse
//   busy_o        FSM not idle
//   pause_o       stall request to the pipeline controller
module div_ctrl #(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start_i,
    input  logic              signed_i,
    input  logic              mod_i,
    input  logic [DATA_W-1:0] dividend_i,
    input  logic [DATA_W-1:0] divisor_i,
    input  logic              cancel_i,
    output logic [DATA_W-1:0] result_o,
    output logic              valid_o,
    output logic              busy_o,
    output logic              pause_o
);
    localparam int CNT_W = $clog2(DATA_W);

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [DATA_W-1:0]   rem_q, rem_d;     // partial remainder
    logic [DATA_W-1:0]   dvd_q, dvd_d;     // dividend magnitude, shifts into quotient
    logic [DATA_W-1:0]   dsr_q, dsr_d;     // divisor magnitude
    logic                qneg_q, qneg_d;
    logic                rneg_q, rneg_d;
    logic                mod_q, mod_d;
    logic [DATA_W-1:0]   op_a_q, op_a_d;
    logic [DATA_W-1:0]   op_b_q, op_b_d;
    logic                sgn_q, sgn_d;
    logic [DATA_W-1:0]   result_q, result_d;
    logic                c_vld_q, c_vld_d;
    logic [DATA_W-1:0]   c_a_q, c_a_d;
    logic [DATA_W-1:0]   c_b_q, c_b_d;
    logic                c_sgn_q, c_sgn_d;
    logic [DATA_W-1:0]   c_quo_q, c_quo_d;
    logic [DATA_W-1:0]   c_rem_q, c_rem_d;

    logic                a_neg, b_neg, cache_hit, ge;
    logic [DATA_W-1:0]   a_mag, b_mag, rem_sub, quo_fix, rem_fix, done_res;
    logic [DATA_W:0]     shifted;

    always_comb begin
        a_neg     = signed_i & dividend_i[DATA_W-1];
        b_neg     = signed_i & divisor_i[DATA_W-1];
        a_mag     = a_neg ? -dividend_i : dividend_i;
        b_mag     = b_neg ? -divisor_i  : divisor_i;
        cache_hit = c_vld_q && (dividend_i == c_a_q) && (divisor_i == c_b_q)
                    && (signed_i == c_sgn_q);
        // Next remainder candidate: {rem, dvd} shifted left by one.
        shifted   = {rem_q, dvd_q[DATA_W-1]};
        ge        = shifted >= {1'b0, dsr_q};
        // When ge holds the difference is below the divisor, so it fits DATA_W bits.
        rem_sub   = shifted[DATA_W-1:0] - dsr_q;
        quo_fix   = qneg_q ? -dvd_q : dvd_q;
        rem_fix   = rneg_q ? -rem_q : rem_q;
        done_res  = mod_q ? rem_fix : quo_fix;
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        rem_d    = rem_q;
        dvd_d    = dvd_q;
        dsr_d    = dsr_q;
        qneg_d   = qneg_q;
        rneg_d   = rneg_q;
        mod_d    = mod_q;
        op_a_d   = op_a_q;
        op_b_d   = op_b_q;
        sgn_d    = sgn_q;
        result_d = result_q;
        c_vld_d  = c_vld_q;
        c_a_d    = c_a_q;
        c_b_d    = c_b_q;
        c_sgn_d  = c_sgn_q;
        c_quo_d  = c_quo_q;
        c_rem_d  = c_rem_q;

        case (state_q)
            IDLE: begin
                if (start_i && !cancel_i) begin
                    op_a_d = dividend_i;
                    op_b_d = divisor_i;
                    sgn_d  = signed_i;
                    mod_d  = mod_i;
                    if (divisor_i == '0) begin
                        // Final values loaded directly; zero sign flags make the fix a no-op.
                        dvd_d   = '1;
                        rem_d   = dividend_i;
                        qneg_d  = 1'b0;
                        rneg_d  = 1'b0;
                        state_d = DONE;
                    end else if (cache_hit) begin
                        dvd_d   = c_quo_q;
                        rem_d   = c_rem_q;
                        qneg_d  = 1'b0;
                        rneg_d  = 1'b0;
                        state_d = DONE;
                    end else begin
                        dvd_d   = a_mag;
                        dsr_d   = b_mag;
                        rem_d   = '0;
                        cnt_d   = '0;
                        qneg_d  = a_neg ^ b_neg;
                        rneg_d  = a_neg;
                        state_d = CALC;
                    end
                end
            end
            CALC: begin
                if (cancel_i) begin
                    state_d = IDLE;
                end else begin
                    rem_d = ge ? rem_sub : shifted[DATA_W-1:0];
                    dvd_d = {dvd_q[DATA_W-2:0], ge};
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == CNT_W'(DATA_W-1)) begin
                        cnt_d   = '0;
                        state_d = DONE;
                    end
                end
            end
            DONE: begin
                // Cache is written even on cancel: the result itself is correct.
                result_d = done_res;
                c_vld_d  = 1'b1;
                c_a_d    = op_a_q;
                c_b_d    = op_b_q;
                c_sgn_d  = sgn_q;
                c_quo_d  = quo_fix;
                c_rem_d  = rem_fix;
                state_d  = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            rem_q    <= '0;
            dvd_q    <= '0;
            dsr_q    <= '0;
            qneg_q   <= 1'b0;
            rneg_q   <= 1'b0;
            mod_q    <= 1'b0;
            op_a_q   <= '0;
            op_b_q   <= '0;
            sgn_q    <= 1'b0;
            result_q <= '0;
            c_vld_q  <= 1'b0;
            c_a_q    <= '0;
            c_b_q    <= '0;
            c_sgn_q  <= 1'b0;
            c_quo_q  <= '0;
            c_rem_q  <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            rem_q    <= rem_d;
            dvd_q    <= dvd_d;
            dsr_q    <= dsr_d;
            qneg_q   <= qneg_d;
            rneg_q   <= rneg_d;
            mod_q    <= mod_d;
            op_a_q   <= op_a_d;
            op_b_q   <= op_b_d;
            sgn_q    <= sgn_d;
            result_q <= result_d;
            c_vld_q  <= c_vld_d;
            c_a_q    <= c_a_d;
            c_b_q    <= c_b_d;
            c_sgn_q  <= c_sgn_d;
            c_quo_q  <= c_quo_d;
            c_rem_q  <= c_rem_d;
        end
    end

    // In DONE the result comes straight from the sign-fixed registers, then
    // result_q holds it until the next DONE.
    assign valid_o  = (state_q == DONE);
    assign busy_o   = (state_q != IDLE);
    assign result_o = valid_o ? done_res : result_q;
    assign pause_o  = start_i & ~valid_o & ~cancel_i;
endmodule
